// File: rtl/la_spram_pkg.sv
// Shared types and elaboration-time helpers for the la_spram controller family.
package la_spram_pkg;

    typedef enum logic {
        INIT_SWEEP = 1'b0,
        RUN        = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Response-buffer depth needed to cover every read in flight.
    function automatic int rdepth(input int oreg);
        return 2 + oreg;
    endfunction

endpackage

// File: rtl/la_spram.sv
// Single-port memory macro wrapper: masked write, synchronous read, one-cycle read latency.
module la_spram #(
    parameter int    DW    = 32,
    parameter int    AW    = 10,
    parameter string TYPE  = "DEFAULT",
    parameter int    CTRLW = 128,
    parameter int    TESTW = 128
) (
    input  logic             clk,
    input  logic             ce,
    input  logic             we,
    input  logic [DW-1:0]    wmask,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    input  logic             vss,
    input  logic             vdd,
    input  logic             vddio,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [TESTW-1:0] test
);

    localparam bit DEFAULT_MACRO = (TYPE == "DEFAULT");

    logic [DW-1:0] ram [2**AW];
    logic          unused_ok;

    // Hard-macro control, test and power pins have no meaning in the behavioural array.
    assign unused_ok = ^{ctrl, test, vss, vdd, vddio, DEFAULT_MACRO};

    always_ff @(posedge clk) begin
        if (ce && we) begin
            ram[addr] <= (ram[addr] & ~wmask) | (din & wmask);
        end
        if (ce && !we) begin
            dout <= ram[addr];
        end
    end

endmodule

// File: rtl/la_spram_rspbuf.sv
// First-word-fall-through response FIFO; an arriving word bypasses storage when the FIFO is empty.
module la_spram_rspbuf
    import la_spram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : mem[rd_ptr];
    assign pop       = !empty && out_ready;
    assign push      = in_valid && !(empty && out_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // The controller's credit counter must make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/la_spram_ctrl.sv
// Valid/ready request/response controller around la_spram with credit-based backpressure,
// optional output register and optional post-reset clear sweep.
module la_spram_ctrl
    import la_spram_pkg::*;
#(
    parameter int            DW      = 32,
    parameter int            AW      = 10,
    parameter string         TYPE    = "DEFAULT",
    parameter int            CTRLW   = 128,
    parameter int            TESTW   = 128,
    parameter int            OREG    = 0,
    parameter int            INIT    = 0,
    parameter logic [DW-1:0] INITVAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [DW-1:0]    req_wmask,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_din,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_dout,
    output logic             init_busy,
    input  logic             vss,
    input  logic             vdd,
    input  logic             vddio,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [TESTW-1:0] test
);

    localparam int RD = rdepth(OREG);
    localparam int OW = clog2(RD + 1);

    state_t        state;
    logic [AW-1:0] sweep_addr;
    logic          run_q;
    logic [OW-1:0] outstanding;
    logic          accept;
    logic          rd_accept;
    logic          pop;
    logic          rd_p1;
    logic          cap_valid;
    logic [DW-1:0] cap_data;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wmask;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    // Handshakes: a beat transfers on a rising clk edge where valid && ready are both high;
    // req_ready and rsp_valid are decided from registered state only, never from the partner's signal.
    assign req_ready = run_q && (outstanding < OW'(RD));
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= (INIT != 0) ? INIT_SWEEP : RUN;
            sweep_addr <= '0;
            init_busy  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q <= (state == RUN);
            if (state == INIT_SWEEP) begin
                if (!init_busy) begin
                    init_busy <= 1'b1;
                end else begin
                    sweep_addr <= sweep_addr + 1'b1;
                    if (sweep_addr == '1) begin
                        init_busy <= 1'b0;
                        state     <= RUN;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            rd_p1       <= 1'b0;
        end else begin
            outstanding <= outstanding + OW'(rd_accept) - OW'(pop);
            rd_p1       <= rd_accept;
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic          rd_p2;
            logic [DW-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (rst) rd_p2 <= 1'b0;
                else     rd_p2 <= rd_p1;
            end

            always_ff @(posedge clk) begin
                if (rd_p1) dout_q <= mem_dout;
            end

            assign cap_valid = rd_p2;
            assign cap_data  = dout_q;
        end else begin : g_no_oreg
            assign cap_valid = rd_p1;
            assign cap_data  = mem_dout;
        end
    endgenerate

    // The sweep owns the macro port; req_ready is low throughout, so no request can collide.
    assign mem_ce    = init_busy || accept;
    assign mem_we    = init_busy || req_we;
    assign mem_addr  = init_busy ? sweep_addr : req_addr;
    assign mem_wmask = init_busy ? {DW{1'b1}} : req_wmask;
    assign mem_din   = init_busy ? INITVAL : req_din;

    la_spram #(
        .DW    (DW),
        .AW    (AW),
        .TYPE  (TYPE),
        .CTRLW (CTRLW),
        .TESTW (TESTW)
    ) u_spram (
        .clk   (clk),
        .ce    (mem_ce),
        .we    (mem_we),
        .wmask (mem_wmask),
        .addr  (mem_addr),
        .din   (mem_din),
        .dout  (mem_dout),
        .vss   (vss),
        .vdd   (vdd),
        .vddio (vddio),
        .ctrl  (ctrl),
        .test  (test)
    );

    la_spram_rspbuf #(
        .WIDTH (DW),
        .DEPTH (RD)
    ) u_rspbuf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (cap_valid),
        .in_data   (cap_data),
        .out_valid (rsp_valid),
        .out_ready (rsp_ready),
        .out_data  (rsp_dout)
    );

endmodule
